// File: rtl/seq_evt_pkg.sv
// Shared types and helpers for the sequence event logger.
// Holds default widths, the record type and a saturating increment.
package seq_evt_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 8;

  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [CNT_W_DEF-1:0] idx;
  } evt_rec_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_event_logger_if.sv
// Event record drain port: valid/ready plus head record fields.
// master = logger (drives valid/record), slave = consumer (drives ready).
interface seq_event_logger_if #(
  parameter int TS_WIDTH  = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 ev_valid;
  logic                 ev_ready;
  logic [TS_WIDTH-1:0]  ev_timestamp;
  logic [CNT_WIDTH-1:0] ev_index;

  modport master (
    output ev_valid, ev_timestamp, ev_index,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_timestamp, ev_index,
    output ev_ready
  );
endinterface

// File: rtl/seq_evt_fifo.sv
// Synchronous first-word-fall-through FIFO of records with clear.
// Ports: i_push/i_din, i_pop/o_dout, o_full, o_empty, o_level.
module seq_evt_fifo
  import seq_evt_pkg::*;
#(
  parameter type T     = evt_rec_t,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clear,
  input  logic          i_push,
  input  T              i_din,
  input  logic          i_pop,
  output T              o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_lvl;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_lvl == LW'(DEPTH));
  assign o_empty = (r_lvl == '0);
  assign o_level = r_lvl;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // Head is forced to zero when empty so outputs read 0 after reset.
  assign o_dout  = o_empty ? T'('0) : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push && reset_n && !i_clear) begin
      r_mem[r_wr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_lvl <= r_lvl + LW'(1);
        2'b01:   r_lvl <= r_lvl - LW'(1);
        default: r_lvl <= r_lvl;
      endcase
    end
  end

endmodule

// File: rtl/seq_event_logger.sv
// Timestamps rising edges of sequence_found into a FWFT record FIFO.
// Ports: clk, reset_n, sequence_found, clear, ev (drain), counters, level.
module seq_event_logger
  import seq_evt_pkg::*;
#(
  parameter int  TS_WIDTH  = TS_W_DEF,
  parameter int  CNT_WIDTH = CNT_W_DEF,
  parameter int  DEPTH     = 4,
  localparam int LW        = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sequence_found,
  input  logic                 clear,
  seq_event_logger_if.master   ev,
  output logic [CNT_WIDTH-1:0] det_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [LW-1:0]        fifo_level
);

  typedef struct packed {
    logic [TS_WIDTH-1:0]  ts;
    logic [CNT_WIDTH-1:0] idx;
  } rec_t;

  localparam logic [31:0] CNT_MAX =
    32'((64'd1 << CNT_WIDTH) - 64'd1);

  logic                 r_prev;
  logic [TS_WIDTH-1:0]  r_ts;
  logic [CNT_WIDTH-1:0] r_det;
  logic [CNT_WIDTH-1:0] r_drop;
  logic                 w_event;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  rec_t                 w_rec;
  rec_t                 w_head;

  assign w_event = sequence_found & ~r_prev;
  assign w_pop   = ev.ev_ready & ~w_empty;
  // A full FIFO still accepts when its head leaves this cycle.
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_rec   = '{ts: r_ts, idx: r_det};

  // Edge history survives clear; only reset zeroes it.
  always_ff @(posedge clk) begin
    if (!reset_n) r_prev <= 1'b0;
    else          r_prev <= sequence_found;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_ts   <= '0;
      r_det  <= '0;
      r_drop <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
      if (w_event) begin
        r_det <= CNT_WIDTH'(sat_inc(32'(r_det), CNT_MAX));
        if (!w_push) begin
          r_drop <= CNT_WIDTH'(sat_inc(32'(r_drop), CNT_MAX));
        end
      end
    end
  end

  seq_evt_fifo #(
    .T     (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (clear),
    .i_push  (w_push),
    .i_din   (w_rec),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign ev.ev_valid     = ~w_empty;
  assign ev.ev_timestamp = w_head.ts;
  assign ev.ev_index     = w_head.idx;
  assign det_count       = r_det;
  assign drop_count      = r_drop;

endmodule

// File: tb/tb_seq_event_logger.sv
// Random-stimulus scoreboard bench for two logger builds.
// Build a: 16-bit ts / 8-bit counters; build b: 4-bit ts / 2-bit counters.
module tb_seq_event_logger;
  import seq_evt_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic clear;
  logic sf;
  logic rdy;

  seq_event_logger_if #(.TS_WIDTH(16), .CNT_WIDTH(8)) if_a ();
  seq_event_logger_if #(.TS_WIDTH(4),  .CNT_WIDTH(2)) if_b ();
  assign if_a.ev_ready = rdy;
  assign if_b.ev_ready = rdy;

  logic [7:0]    det_a, drop_a;
  logic [1:0]    det_b, drop_b;
  logic [LW-1:0] lvl_a, lvl_b;

  seq_event_logger #(
    .TS_WIDTH(16), .CNT_WIDTH(8), .DEPTH(DEPTH)
  ) u_a (
    .clk            (clk),
    .reset_n        (reset_n),
    .sequence_found (sf),
    .clear          (clear),
    .ev             (if_a),
    .det_count      (det_a),
    .drop_count     (drop_a),
    .fifo_level     (lvl_a)
  );

  seq_event_logger #(
    .TS_WIDTH(4), .CNT_WIDTH(2), .DEPTH(DEPTH)
  ) u_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .sequence_found (sf),
    .clear          (clear),
    .ev             (if_b),
    .det_count      (det_b),
    .drop_count     (drop_b),
    .fifo_level     (lvl_b)
  );

  // Reference model: occupancy, cycles since reset/clear,
  // detection and drop totals, per build.
  int          tsw [2] = '{16, 4};
  int          cw  [2] = '{8, 2};
  int          m_lvl [2];
  int          m_cyc [2];
  int          m_det [2];
  int          m_drop [2];
  bit          m_prev [2];
  logic [63:0] sbq [2][$];

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  function automatic int cmax(int d);
    return (1 << cw[d]) - 1;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset(int d, bit keep_prev);
    m_lvl[d]  = 0;
    m_cyc[d]  = 0;
    m_det[d]  = 0;
    m_drop[d] = 0;
    if (!keep_prev) m_prev[d] = 1'b0;
    sbq[d].delete();
  endtask

  // Applies the inputs that the DUT just sampled at this edge.
  task automatic model_step(int d);
    bit ev;
    int ts;
    if (!reset_n) begin
      model_reset(d, 1'b0);
    end else begin
      ev = sf && !m_prev[d];
      m_prev[d] = sf;
      if (clear) begin
        model_reset(d, 1'b1);
      end else begin
        if (m_lvl[d] > 0 && rdy) m_lvl[d]--;
        if (ev) begin
          ts = m_cyc[d] % (1 << tsw[d]);
          if (m_lvl[d] < DEPTH) begin
            sbq[d].push_back({32'(ts), 32'(m_det[d])});
            m_lvl[d]++;
          end else begin
            m_drop[d] = imin(m_drop[d] + 1, cmax(d));
          end
          m_det[d] = imin(m_det[d] + 1, cmax(d));
        end
        m_cyc[d]++;
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check(int d, logic v, logic [31:0] ts,
                       logic [31:0] idx, logic [31:0] det,
                       logic [31:0] drop, logic [31:0] lvl);
    logic [63:0] h;
    string       s;
    s = (d == 0) ? "a" : "b";
    chk({"valid_", s}, 32'(v), 32'(m_lvl[d] != 0));
    chk({"level_", s}, lvl, 32'(m_lvl[d]));
    chk({"det_", s}, det, 32'(m_det[d]));
    chk({"drop_", s}, drop, 32'(m_drop[d]));
    if (v) begin
      if (sbq[d].size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL head_%s: got valid record expected none at %0t",
                 s, $time);
      end else begin
        h = sbq[d][0];
        chk({"ts_", s}, ts, h[63:32]);
        chk({"idx_", s}, idx, h[31:0]);
        if (rdy) void'(sbq[d].pop_front());
      end
    end
  endtask

  // Monitor: mid-cycle, compares status and pops on handshakes.
  initial begin
    @(posedge clk);
    while (!done) begin
      @(negedge clk);
      check(0, if_a.ev_valid, 32'(if_a.ev_timestamp),
            32'(if_a.ev_index), 32'(det_a), 32'(drop_a), 32'(lvl_a));
      check(1, if_b.ev_valid, 32'(if_b.ev_timestamp),
            32'(if_b.ev_index), 32'(det_b), 32'(drop_b), 32'(lvl_b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
  endtask

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    sf      = 1'b0;
    rdy     = 1'b0;
    for (int d = 0; d < 2; d++) model_reset(d, 1'b0);
    repeat (3) step();
    reset_n = 1'b1;
    for (int seg = 0; seg < 14; seg++) begin
      int mode;
      int len;
      mode = (seg == 0) ? 0 : int'($urandom_range(0, 3));
      len  = (seg == 0) ? 1100 : 200;
      for (int c = 0; c < len; c++) begin
        reset_n = 1'b1;
        clear   = 1'b0;
        case (mode)
          0: begin
            sf  = ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 9) < 6);
          end
          1: begin
            sf  = ($urandom_range(0, 9) < 4);
            rdy = ($urandom_range(0, 7) == 0);
          end
          2: begin
            sf    = ($urandom_range(0, 1) == 1);
            rdy   = 1'b1;
            clear = ($urandom_range(0, 99) < 3);
          end
          default: begin
            sf      = ($urandom_range(0, 1) == 1);
            rdy     = ($urandom_range(0, 1) == 1);
            clear   = ($urandom_range(0, 99) < 3);
            reset_n = !($urandom_range(0, 99) < 2);
          end
        endcase
        step();
      end
    end
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_event_logger.md
Name: seq_event_logger

Overview:
- Downstream consumer of the sequence detector's sequence_found output.
- Turns each detection into a timestamped event record and buffers the records in a small FIFO.
- Records are drained by a valid/ready consumer (host/debug port).
- Keeps saturating statistics: detections and dropped events.

Parameters:
TS_WIDTH, 16, width of free-running timestamp counter (wraps)
CNT_WIDTH, 8, width of det_count, drop_count, ev_index (saturating)
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
sequence_found  in  1  detection flag from sequence detector (may stay high >1 cycle)
clear  in  1  synchronous clear of counters, timestamp and FIFO
ev_valid  out  1  FIFO head holds a valid record
ev_ready  in  1  consumer accepts the head record
ev_timestamp  out  TS_WIDTH  timestamp of head record
ev_index  out  CNT_WIDTH  detection ordinal of head record
det_count  out  CNT_WIDTH  detections seen since reset/clear, saturating
drop_count  out  CNT_WIDTH  events lost to a full FIFO, saturating
fifo_level  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (reset_n=0 at a clock edge): all outputs 0, FIFO empty, ts counter 0, edge register (prev) 0. No asynchronous path.
- ts counter: increments every cycle and wraps modulo 2^TS_WIDTH. It reads 0 in the first cycle after reset/clear release.
- Event = rising edge: sequence_found=1 and prev=0. prev <= sequence_found every cycle.
  - A level held N cycles produces exactly one event.
  - High in the first cycle after reset counts as an event.
- Record contents: {ts counter value in the event cycle (pre-increment), det_count value before increment}.
- det_count: +1 per event, saturates at 2^CNT_WIDTH-1. ev_index saturates with it.
- FIFO is first-word-fall-through.
  - ev_valid = (level != 0).
  - ev_timestamp/ev_index show the head and are held stable while ev_valid=1 and ev_ready=0.
  - Pop when ev_valid & ev_ready.
- Latency: event sampled at edge N into an empty FIFO gives ev_valid=1 from edge N+1.
- Push when event and (level<DEPTH or pop in the same cycle).
- Full, no pop, event: record dropped, drop_count +1 (saturating), det_count still increments.
- Simultaneous push and pop: level unchanged; pop on an empty FIFO is impossible (ev_valid=0).
- ev_valid=0 ignores ev_ready.
- clear=1: same effect as reset except prev, which still updates normally.
  - Any event in the same cycle is discarded and not counted.
  - clear has priority over push/pop.
- Pointers wrap modulo DEPTH; level is a separate counter, 0..DEPTH.
- Priority: reset_n > clear > push/pop.

Decomposition:
- Package seq_evt_pkg holds:
  - TS_WIDTH/CNT_WIDTH defaults.
  - Record type evt_rec_t {ts, idx}.
  - Saturating-increment function.
- Sub-module seq_evt_fifo: generic sync FWFT FIFO of evt_rec_t with push/pop/full/empty/level and a clear input.
- Top module holds the edge detect, ts counter, statistics counters and drop logic.

Test Plan:
1. Reset 3 cycles, release; ev_ready=1; sequence_found=1 for 1 cycle at cycle 5 -> ev_valid=1 for exactly one cycle at cycle 6, ev_timestamp=5, ev_index=0, det_count=1, drop_count=0.
2. sequence_found high for cycles 10-12 -> single record, ts=10, det_count increments by 1 only.
3. ev_ready=0, DEPTH=4, six 1-cycle pulses at cycles 2,4,6,8,10,12 -> fifo_level=4, det_count=6, drop_count=2.
   - Then ev_ready=1 drains ts 2,4,6,8 with idx 0,1,2,3, ev_valid stays high 4 consecutive cycles, then level=0.
4. FIFO full, ev_ready=0; pulse coinciding with ev_ready=1 for one cycle -> head popped, new record accepted, level stays 4, drop_count unchanged.
5. Mid-operation (level=3, det_count=7), assert clear in the same cycle as a pulse -> next cycle level=0, ev_valid=0, det_count=0, drop_count=0, ts=0, no record of that pulse.
   - Repeat with reset_n=0 instead of clear: same result.
6. TS_WIDTH=4 build, pulse at cycle 17 after reset -> ev_timestamp=1.
   - CNT_WIDTH=2 build, 5 pulses -> det_count=3, last ev_index=3.
